// File: rtl/l2_cache_responder.sv
// l2_cache_responder: unified 2-way set-associative write-back L2 with true LRU.
// Responds to victim-cache line requests upstream and initiates line reads and
// writebacks to physical memory downstream.
// Optional build macro L2_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module l2_cache_responder #(
    parameter int SETS   = 8,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l2_read,
    input  logic              l2_write,
    input  logic [15:0]       l2_address,
    input  logic [LINE_W-1:0] l2_wdata,
    output logic [LINE_W-1:0] l2_rdata,
    output logic              l2_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [15:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
`ifdef L2_PERF_CNT_EN
    ,
    output logic [15:0]       perf_hits,
    output logic [15:0]       perf_misses,
    output logic [15:0]       perf_writebacks
`endif
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 16 - 5 - INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAG_CHECK,
        S_WRITEBACK,
        S_FILL
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched request (offset bits are never needed)
    logic [15:5]       r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_op_wr;

    // Per-way storage; tags and data are never reset, only the state bits are
    logic [TAG_W-1:0]  r_tag  [2][SETS];
    logic [LINE_W-1:0] r_data [2][SETS];
    logic [SETS-1:0]   r_valid [2];
    logic [SETS-1:0]   r_dirty [2];
    logic [SETS-1:0]   r_lru;       // per set: way to replace next

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    logic               w_hit_way;
    logic               w_victim;
    logic               w_vic_valid;
    logic               w_vic_dirty;
    logic [TAG_W-1:0]   w_vic_tag;
    logic [LINE_W-1:0]  w_vic_data;
    logic               w_latch;
    logic               w_hit_upd;
    logic               w_install;
    logic               w_wb_done;
    logic               w_fill_done;
    logic               w_unused_offset;

    assign w_unused_offset = ^l2_address[4:0];

    assign w_index     = r_addr[5 +: INDEX_W];
    assign w_tag       = r_addr[15 -: TAG_W];
    assign w_hit0      = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
    assign w_hit1      = r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
    assign w_hit       = w_hit0 || w_hit1;
    assign w_hit_way   = w_hit1;
    assign w_victim    = r_lru[w_index];
    assign w_vic_valid = r_valid[w_victim][w_index];
    assign w_vic_dirty = r_dirty[w_victim][w_index];
    assign w_vic_tag   = r_tag[w_victim][w_index];
    assign w_vic_data  = r_data[w_victim][w_index];

    // Next-state, handshake outputs and array update strobes
    always_comb begin
        w_next       = r_state;
        l2_rdata     = '0;
        l2_mem_resp  = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        w_latch      = 1'b0;
        w_hit_upd    = 1'b0;
        w_install    = 1'b0;
        w_wb_done    = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (l2_read || l2_write) begin
                    w_latch = 1'b1;
                    w_next  = S_TAG_CHECK;
                end
            end
            S_TAG_CHECK: begin
                if (w_hit) begin
                    l2_mem_resp = 1'b1;
                    w_hit_upd   = 1'b1;
                    if (!r_op_wr) begin
                        l2_rdata = r_data[w_hit_way][w_index];
                    end
                    w_next = S_IDLE;
                end else if (w_vic_valid && w_vic_dirty) begin
                    w_next = S_WRITEBACK;
                end else if (r_op_wr) begin
                    // Full-line write: no fetch needed, install directly
                    l2_mem_resp = 1'b1;
                    w_install   = 1'b1;
                    w_next      = S_IDLE;
                end else begin
                    w_next = S_FILL;
                end
            end
            S_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {w_vic_tag, w_index, 5'b0};
                pmem_wdata   = w_vic_data;
                if (pmem_resp) begin
                    w_wb_done = 1'b1;
                    w_next    = S_TAG_CHECK;
                end
            end
            S_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_index, 5'b0};
                if (pmem_resp) begin
                    w_fill_done = 1'b1;
                    w_next      = S_TAG_CHECK;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register plus valid/dirty/LRU bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op_wr    <= 1'b0;
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_dirty[0] <= '0;
            r_dirty[1] <= '0;
            r_lru      <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_op_wr <= l2_write;
            end
            if (w_hit_upd) begin
                r_lru[w_index] <= ~w_hit_way;
                if (r_op_wr) begin
                    r_dirty[w_hit_way][w_index] <= 1'b1;
                end
            end
            if (w_install) begin
                r_valid[w_victim][w_index] <= 1'b1;
                r_dirty[w_victim][w_index] <= 1'b1;
                r_lru[w_index]             <= ~w_victim;
            end
            if (w_wb_done) begin
                r_dirty[w_victim][w_index] <= 1'b0;
            end
            if (w_fill_done) begin
                r_valid[w_victim][w_index] <= 1'b1;
                r_dirty[w_victim][w_index] <= 1'b0;
            end
        end
    end

    // Request capture and tag/data array writes (no reset needed)
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_addr  <= l2_address[15:5];
            r_wdata <= l2_wdata;
        end
        if (w_hit_upd && r_op_wr) begin
            r_data[w_hit_way][w_index] <= r_wdata;
        end
        if (w_install) begin
            r_data[w_victim][w_index] <= r_wdata;
            r_tag[w_victim][w_index]  <= w_tag;
        end
        if (w_fill_done) begin
            r_data[w_victim][w_index] <= pmem_rdata;
            r_tag[w_victim][w_index]  <= w_tag;
        end
    end

`ifdef L2_PERF_CNT_EN
    logic r_first;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counters: hit/miss classified on the first tag check of each request only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first         <= 1'b0;
            perf_hits       <= '0;
            perf_misses     <= '0;
            perf_writebacks <= '0;
        end else begin
            if (w_latch) begin
                r_first <= 1'b1;
            end else if (r_state == S_TAG_CHECK) begin
                r_first <= 1'b0;
                if (r_first) begin
                    if (w_hit) begin
                        perf_hits <= sat_inc(perf_hits);
                    end else begin
                        perf_misses <= sat_inc(perf_misses);
                    end
                end
            end
            if (w_wb_done) begin
                perf_writebacks <= sat_inc(perf_writebacks);
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_cache_responder.sv
// Directed self-checking bench for l2_cache_responder with a simple
// fixed-latency physical-memory responder.
module tb_l2_cache_responder;

    logic         clk;
    logic         rst_n;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata;
    logic         l2_mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
`ifdef L2_PERF_CNT_EN
    logic [15:0]  perf_hits;
    logic [15:0]  perf_misses;
    logic [15:0]  perf_writebacks;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    l2_cache_responder #(.SETS(8), .LINE_W(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_rdata     (l2_rdata),
        .l2_mem_resp  (l2_mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
`ifdef L2_PERF_CNT_EN
        ,
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses),
        .perf_writebacks (perf_writebacks)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // One upstream request (op 0=read, 1=write, 2=both). Services pmem with
    // 'lat' cycles of latency and reports what was seen, plus 3 trailing cycles.
    task automatic txn(input int op, input logic [15:0] addr, input logic [255:0] wd,
                       input logic [255:0] fill, input int lat,
                       output int cyc, output logic [255:0] rd, output int nresp,
                       output int nwb, output logic [15:0] wba, output logic [255:0] wbd,
                       output int nrd, output logic [15:0] rda);
        int  pm_cnt;
        bit  pm_act;
        int  tail;
        cyc = 0; rd = '0; nresp = 0; nwb = 0; nrd = 0;
        wba = '0; wbd = '0; rda = '0;
        pm_cnt = 0; pm_act = 0; tail = -1;
        @(negedge clk);
        l2_address = addr;
        l2_wdata   = wd;
        l2_read    = (op != 1);
        l2_write   = (op != 0);
        for (int c = 1; c <= 300; c++) begin
            #1;
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            if (l2_mem_resp) begin
                nresp++;
                if (cyc == 0) begin
                    cyc = c;
                    rd  = l2_rdata;
                end
                l2_read  = 1'b0;
                l2_write = 1'b0;
                tail     = 3;
            end
            if (pmem_write || pmem_read) begin
                if (!pm_act) begin
                    pm_act = 1;
                    pm_cnt = 0;
                    if (pmem_write) begin
                        nwb++;
                        wba = pmem_address;
                        wbd = pmem_wdata;
                    end else begin
                        nrd++;
                        rda = pmem_address;
                    end
                end
                pm_cnt++;
                if (pm_cnt >= lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = fill;
                    pm_act     = 0;
                end
            end
            if (tail == 0) break;
            if (tail > 0) tail--;
            @(negedge clk);
        end
        l2_read  = 1'b0;
        l2_write = 1'b0;
    endtask

    initial begin
        int           cyc, nresp, nwb, nrd;
        logic [255:0] rd, wbd;
        logic [15:0]  wba, rda;
        logic [255:0] d1, d2, d3, d4, d5, d6, daa, dw, db;
        bit           ok;

        d1  = {8{32'h1111_0001}};
        d2  = {8{32'h2222_0002}};
        d3  = {8{32'h3333_0003}};
        d4  = {8{32'h4444_0004}};
        d5  = {8{32'h5555_0005}};
        d6  = {8{32'h6666_0006}};
        daa = {32{8'hAA}};
        dw  = {8{32'hDEAD_BEEF}};
        db  = {8{32'hB0B0_C1C1}};

        rst_n = 1'b0; l2_read = 1'b0; l2_write = 1'b0;
        l2_address = '0; l2_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_resp",  l2_mem_resp, 1'b0);
        chk("rst_pread", pmem_read,   1'b0);
        chk("rst_pwrite", pmem_write, 1'b0);
        chk("rst_paddr", pmem_address, 16'h0);
        chk("rst_rdata", l2_rdata, '0);
        rst_n = 1'b1;

        // Cold read miss into set 2
        txn(0, 16'h1240, '0, d1, 2, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("cold_lat",   cyc, 5);
        chk("cold_data",  rd, d1);
        chk("cold_nresp", nresp, 1);
        chk("cold_nrd",   nrd, 1);
        chk("cold_raddr", rda, 16'h1240);
        chk("cold_nwb",   nwb, 0);

        // Repeat read hits
        txn(0, 16'h1240, '0, '0, 2, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("hit_lat",  cyc, 2);
        chk("hit_data", rd, d1);
        chk("hit_pmem", nrd + nwb, 0);

        // Write hit then read back
        txn(1, 16'h1240, daa, '0, 2, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("whit_lat",  cyc, 2);
        chk("whit_pmem", nrd + nwb, 0);
        txn(0, 16'h1240, '0, '0, 2, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("whit_rback", rd, daa);

        // Second line in set 2 fills the other way; 0x1240 becomes LRU
        txn(0, 16'h1340, '0, d2, 2, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("fill2_lat",  cyc, 5);
        chk("fill2_data", rd, d2);
        chk("fill2_nwb",  nwb, 0);

        // Dirty eviction: writeback of 0x1240 then fill of 0x1440
        txn(0, 16'h1440, '0, d3, 2, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("evict_lat",   cyc, 8);
        chk("evict_nwb",   nwb, 1);
        chk("evict_waddr", wba, 16'h1240);
        chk("evict_wdata", wbd, daa);
        chk("evict_nrd",   nrd, 1);
        chk("evict_raddr", rda, 16'h1440);
        chk("evict_data",  rd, d3);
        chk("evict_nresp", nresp, 1);
`ifdef L2_PERF_CNT_EN
        chk("perf_wb",   perf_writebacks, 16'd1);
        chk("perf_miss", perf_misses, 16'd3);
        chk("perf_hit",  perf_hits, 16'd3);
`endif

        // Write miss into empty set 0: no pmem traffic
        txn(1, 16'h2000, dw, '0, 2, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("wmiss_lat",   cyc, 2);
        chk("wmiss_pmem",  nrd + nwb, 0);
        chk("wmiss_nresp", nresp, 1);
        txn(0, 16'h2100, '0, d4, 3, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("set0_fill_lat", cyc, 6);
        chk("set0_fill_nwb", nwb, 0);
        // Installed write line is dirty and gets written back on eviction
        txn(0, 16'h2200, '0, d5, 1, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("wmiss_ev_lat",   cyc, 6);
        chk("wmiss_ev_waddr", wba, 16'h2000);
        chk("wmiss_ev_wdata", wbd, dw);
        chk("wmiss_ev_raddr", rda, 16'h2200);
        chk("wmiss_ev_data",  rd, d5);

        // Read and write both high: write wins (hit on 0x1340)
        txn(2, 16'h1340, db, '0, 2, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("both_lat",  cyc, 2);
        chk("both_rd",   rd, '0);
        txn(0, 16'h1340, '0, '0, 2, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("both_rback", rd, db);

        // Reset in the middle of a fill
        @(negedge clk);
        l2_address = 16'h3000;
        l2_read    = 1'b1;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (pmem_read) begin
                ok = 1;
                break;
            end
        end
        chk("mid_fill_seen", ok, 1'b1);
        chk("mid_fill_addr", pmem_address, 16'h3000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pread", pmem_read, 1'b0);
        chk("mid_rst_resp",  l2_mem_resp, 1'b0);
        chk("mid_rst_paddr", pmem_address, 16'h0);
        l2_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Formerly resident line now misses
        txn(0, 16'h1240, '0, d6, 2, cyc, rd, nresp, nwb, wba, wbd, nrd, rda);
        chk("post_rst_nrd",  nrd, 1);
        chk("post_rst_nwb",  nwb, 0);
        chk("post_rst_lat",  cyc, 5);
        chk("post_rst_data", rd, d6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
